// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Brief    : Slave on the processor dmem bus. Decodes a 16-word window and
//            serves a free-running cycle counter, a one-shot countdown timer
//            with an interrupt flag, a byte TX FIFO with a valid/ready drain
//            port, and a FIFO status register. Read data and the hit flag are
//            registered so the top level can mux q_mmio over the syncram q.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_responder #(
    parameter logic [11:0] BASE       = 12'hF00,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_mmio,
    output logic        sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    // Pointer width stays at least one bit so a depth-1 FIFO still elaborates.
    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [3:0]       DEPTH_CNT = 4'(FIFO_DEPTH);

    localparam logic [3:0] OFF_CYCLE = 4'h0;
    localparam logic [3:0] OFF_TIMER = 4'h1;
    localparam logic [3:0] OFF_TSTAT = 4'h2;
    localparam logic [3:0] OFF_TXD   = 4'h3;
    localparam logic [3:0] OFF_TXS   = 4'h4;

    // Register state
    logic [31:0]      cycle_cnt;
    logic [31:0]      timer_count;
    logic             running;
    logic             expired;
    logic             ovf;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [3:0]       fifo_count;

    // Decode
    logic        hit;
    logic [3:0]  offset;
    logic        wr_timer;
    logic        wr_tstat;
    logic        wr_txd;
    logic        wr_txs;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        timer_expire;
    logic [31:0] read_data;

    assign hit      = (address_dmem[11:4] == BASE[11:4]);
    assign offset   = address_dmem[3:0];
    assign wr_timer = hit && wren && (offset == OFF_TIMER);
    assign wr_tstat = hit && wren && (offset == OFF_TSTAT);
    assign wr_txd   = hit && wren && (offset == OFF_TXD);
    assign wr_txs   = hit && wren && (offset == OFF_TXS);

    assign full     = (fifo_count == DEPTH_CNT);
    assign empty    = (fifo_count == 4'd0);
    assign tx_valid = !empty;
    // Gate the head so an unwritten/stale slot never shows on tx_data.
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO lands.
    assign push     = wr_txd && (!full || pop);
    assign ovf_set  = wr_txd && full && !pop;

    // A count of 1 reaches 0 this edge; a count of 0 (load of 0) expires too.
    // A load on the same edge restarts the timer instead of expiring it.
    assign timer_expire = !wr_timer && running && (timer_count <= 32'd1);

    assign irq = expired;

    // Read mux over the pre-edge register values.
    always_comb begin
        read_data = 32'h0;
        case (offset)
            OFF_CYCLE: read_data = cycle_cnt;
            OFF_TIMER: read_data = timer_count;
            OFF_TSTAT: read_data = {30'h0, running, expired};
            OFF_TXS:   read_data = {25'h0, ovf, empty, full, fifo_count};
            default:   read_data = 32'h0;
        endcase
    end

    // Registered read port: one-cycle latency, zero outside the window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_mmio <= 32'h0;
            sel    <= 1'b0;
        end else begin
            sel    <= hit;
            q_mmio <= hit ? read_data : 32'h0;
        end
    end

    // Free-running cycle counter; natural 32-bit wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Countdown timer: load restarts, otherwise decrement while running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_count <= 32'h0;
            running     <= 1'b0;
        end else if (wr_timer) begin
            timer_count <= data;
            running     <= 1'b1;
        end else if (timer_expire) begin
            timer_count <= 32'h0;
            running     <= 1'b0;
        end else if (running) begin
            timer_count <= timer_count - 32'd1;
        end
    end

    // Sticky expired flag; an expiry beats a clear on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            expired <= 1'b0;
        end else if (timer_expire) begin
            expired <= 1'b1;
        end else if (wr_tstat && data[0]) begin
            expired <= 1'b0;
        end
    end

    // Sticky overflow flag; a dropped byte beats a clear on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (wr_txs && data[6]) begin
            ovf <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data[7:0];
        end
    end

    // FIFO pointers and occupancy, wrapping modulo the depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 4'd1;
                2'b01:   fifo_count <= fifo_count - 4'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_responder
// Brief    : Scoreboard bench for mmio_responder. Stimulus pushes expected
//            responses tagged with the cycle they are due; a monitor checks
//            them one step after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_mmio;
    logic        sel;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    mmio_responder #(.BASE(12'hF00), .FIFO_DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_mmio       (q_mmio),
        .sel          (sel),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    // Kinds: 0 = {sel,q_mmio}, 1 = irq, 2 = {tx_valid,tx_data}
    typedef struct {
        int          due;
        int          kind;
        logic [32:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   compared = 0;
    int   mismatch = 0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        compared++;
        if (act !== exp) begin
            mismatch++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [32:0] actual(input int kind);
        case (kind)
            0:       return {sel, q_mmio};
            1:       return {32'h0, irq};
            default: return {24'h0, tx_valid, tx_data};
        endcase
    endfunction

    task automatic push_exp(input int dly, input int kind, input logic [32:0] v, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due at this edge
    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].name, actual(sb[i].kind), sb[i].exp);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                compared++;
                mismatch++;
                $display("FAIL %s: overdue, required %h", sb[i].name, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        step();
        wren         = 1'b0;
        address_dmem = 12'h000;
        data         = 32'h0;
    endtask

    task automatic do_read(input logic [11:0] a, input logic [32:0] exp, input string name);
        address_dmem = a;
        wren         = 1'b0;
        push_exp(1, 0, exp, name);
        step();
        address_dmem = 12'h000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drain [8];
        drain = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h60};

        reset        = 1'b1;
        address_dmem = 12'h000;
        data         = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        repeat (2) step();
        check("rst_read", {sel, q_mmio}, 33'h0);
        check("rst_irq", {32'h0, irq}, 33'h0);
        check("rst_tx", {24'h0, tx_valid, tx_data}, 33'h0);
        reset = 1'b0;

        // Cycle counter: read at the 5th edge after release returns 4
        repeat (4) step();
        do_read(12'hF00, {1'b1, 32'd4}, "cycle_at_edge5");
        do_read(12'h100, {1'b0, 32'd0}, "miss_read");
        do_read(12'hF07, {1'b1, 32'd0}, "unmapped_offset");

        // Timer of 3: irq rises 3 edges after the write edge
        push_exp(3, 1, 33'h0, "irq_before_expiry");
        push_exp(4, 1, 33'h1, "irq_expiry");
        do_write(12'hF01, 32'd3);
        repeat (3) step();
        do_read(12'hF02, {1'b1, 32'h1}, "tstat_expired");
        push_exp(1, 1, 33'h0, "irq_cleared");
        do_write(12'hF02, 32'h1);

        // Reload 5 while count is 1: no expiry until 5 edges after reload
        do_write(12'hF01, 32'd3);
        repeat (2) step();
        push_exp(1, 1, 33'h0, "irq_reload_no_expiry");
        push_exp(5, 1, 33'h0, "irq_reload_before");
        push_exp(6, 1, 33'h1, "irq_reload_expiry");
        do_write(12'hF01, 32'd5);
        repeat (5) step();
        push_exp(1, 1, 33'h0, "irq_cleared2");
        do_write(12'hF02, 32'h1);

        // FIFO: three pushes held, then drained in order
        do_write(12'hF03, 32'h41);
        do_write(12'hF03, 32'hAB42);
        do_write(12'hF03, 32'h43);
        push_exp(1, 2, {24'h0, 1'b1, 8'h41}, "head_41");
        do_read(12'hF03, {1'b1, 32'h0}, "txd_reads_zero");
        do_read(12'hF04, {1'b1, 32'h03}, "txs_three");
        tx_ready = 1'b1;
        push_exp(1, 2, {24'h0, 1'b1, 8'h42}, "head_42");
        push_exp(2, 2, {24'h0, 1'b1, 8'h43}, "head_43");
        push_exp(3, 2, {24'h0, 1'b0, 8'h00}, "drained_empty");
        repeat (3) step();
        tx_ready = 1'b0;
        do_read(12'hF04, {1'b1, 32'h20}, "txs_empty");

        // Overflow: 9 pushes into 8 slots, 0x58 dropped
        for (int i = 0; i < 9; i++) begin
            do_write(12'hF03, 32'h50 + i);
        end
        push_exp(1, 2, {24'h0, 1'b1, 8'h50}, "head_50");
        do_read(12'hF04, {1'b1, 32'h58}, "txs_full_ovf");
        tx_ready = 1'b1;
        do_write(12'hF03, 32'h60);
        tx_ready = 1'b0;
        do_read(12'hF04, {1'b1, 32'h58}, "txs_full_push_pop");
        do_write(12'hF04, 32'h40);
        push_exp(1, 2, {24'h0, 1'b1, 8'h51}, "head_51");
        do_read(12'hF04, {1'b1, 32'h18}, "txs_ovf_cleared");
        tx_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            push_exp(i, 2, {24'h0, 1'b1, drain[i]}, "drain_seq");
        end
        push_exp(8, 2, {24'h0, 1'b0, 8'h00}, "drain_done");
        repeat (8) step();
        tx_ready = 1'b0;
        do_read(12'hF04, {1'b1, 32'h20}, "txs_empty2");

        // Expiry on the same edge as a TSTAT clear: set wins
        push_exp(3, 1, 33'h1, "irq_set_wins");
        push_exp(4, 1, 33'h1, "irq_still_set");
        do_write(12'hF01, 32'd2);
        step();
        do_write(12'hF02, 32'h1);
        do_read(12'hF02, {1'b1, 32'h1}, "tstat_set_wins");
        push_exp(1, 1, 33'h0, "irq_cleared3");
        do_write(12'hF02, 32'h1);

        // Reset mid-countdown with 4 bytes queued and a read in flight
        do_write(12'hF01, 32'd100);
        for (int i = 0; i < 4; i++) begin
            do_write(12'hF03, 32'h70 + i);
        end
        address_dmem = 12'hF01;
        @(posedge clock);
        #2;
        check("pre_reset_sel", {32'h0, sel}, 33'h1);
        check("pre_reset_tx", {24'h0, tx_valid, tx_data}, {24'h0, 1'b1, 8'h70});
        reset = 1'b1;
        #1;
        check("async_rst_read", {sel, q_mmio}, 33'h0);
        check("async_rst_tx", {24'h0, tx_valid, tx_data}, 33'h0);
        check("async_rst_irq", {32'h0, irq}, 33'h0);
        address_dmem = 12'h000;
        repeat (2) step();
        reset = 1'b0;
        do_read(12'hF00, {1'b1, 32'd0}, "cycle_after_reset");
        do_read(12'hF04, {1'b1, 32'h20}, "txs_after_reset");
        do_read(12'hF01, {1'b1, 32'd0}, "timer_after_reset");
        do_read(12'hF02, {1'b1, 32'd0}, "tstat_after_reset");

        repeat (3) step();
        while (sb.size() > 0) begin
            compared++;
            mismatch++;
            $display("FAIL %s: never checked, required %h", sb[0].name, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatch);
        $finish;
    end

endmodule
`default_nettype wire
